fpdiv: RTL
==========

FPDIV -- requirements
Module: fpdiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a new division; sampled only in IDLE or DONE.
REQ-004 SHALL have port dataa, input, 32 bits: dividend, IEEE-754 single precision; sampled in the start cycle.
REQ-005 SHALL have port datab, input, 32 bits: divisor, IEEE-754 single precision; sampled in the start cycle.
REQ-006 SHALL have port result, output, 32 bits: quotient {sign, exp[7:0], mant[22:0]}; valid while done=1.
REQ-007 SHALL have port done, output, 1 bit: result valid; held until next accepted start or reset.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done rises.
REQ-009 SHALL have port div_by_zero, output, 1 bit: the divisor of the last operation was zero; valid with done.

Function
REQ-010 SHALL implement states IDLE, SETUP, DIVIDE, NORM, DONE.
REQ-011 SHALL move IDLE->SETUP or DONE->SETUP on start=1, latching dataa and datab, clearing done and setting busy on the next edge.
REQ-012 SHALL ignore start in SETUP, DIVIDE and NORM, with no effect on the operation in flight.
REQ-013 SHALL, in SETUP, set sign = dataa[31]^datab[31] for all cases, including specials.
REQ-014 SHALL treat an operand as zero when bits[30:0]==0; exponent field 0 with nonzero mantissa is not handled (no denormals, NaN or Inf decoding).
REQ-015 SHALL, in SETUP with a zero divisor, set result={sign,8'hFF,23'h0} and div_by_zero=1, then go to DONE; a zero divisor takes priority over a zero dividend.
REQ-016 SHALL, in SETUP with a zero dividend and nonzero divisor, set result={sign,31'h0} and div_by_zero=0, then go to DONE.
REQ-017 SHALL otherwise, in SETUP:
  - form 24-bit mantissas ma={1,dataa[22:0]} and mb={1,datab[22:0]};
  - compute a 10-bit signed exponent e = expa - expb + 127;
  - load the 25-bit remainder r=ma, clear the quotient q[24:0] and the iteration counter;
  - go to DIVIDE.
REQ-018 SHALL, in DIVIDE, perform one restoring step per cycle for exactly 25 cycles:
  - if r>=mb, shift in q bit 1 and set r=r-mb; else shift in q bit 0;
  - then shift r left by 1;
  - the final q = floor(ma*2^24/mb).
REQ-019 SHALL, in NORM:
  - if q[24]=1, set mant=q[23:1] and keep e;
  - else set mant=q[22:0] and set e=e-1;
  - truncate, with no rounding.
REQ-020 SHALL, in NORM, flush to {sign,31'h0} if the normalized e<=0 (underflow).
REQ-021 SHALL, in NORM, saturate to {sign,8'hFF,23'h0} if the normalized e>=255 (overflow); div_by_zero=0 in both underflow and overflow cases.
REQ-022 SHALL set the latency with start sampled at edge T:
  - normal case: done=1 and result valid after edge T+28 (SETUP at T+1, DIVIDE at T+2..T+26, NORM at T+27);
  - special cases: done=1 after edge T+2.
REQ-023 SHALL hold result, done and div_by_zero stable in DONE until the next accepted start or reset.
REQ-024 SHALL deassert busy on the same edge that done asserts.

Reset
REQ-025 SHALL, on reset=1, go to IDLE and set done=0, busy=0, div_by_zero=0 and result=32'h0 on the next edge, including mid-operation.
REQ-026 SHALL give reset priority over start in the same cycle.
REQ-027 SHALL let start=1 in the first cycle after reset deasserts begin a new operation normally.

Verification
REQ-028 SHALL cover 0x40C00000 / 0x40000000 (6/2) -> result 0x40400000, done=1 exactly at T+28, busy high T+1..T+27.
REQ-029 SHALL cover 0x3F800000 / 0x40400000 (1/3) -> result 0x3EAAAAAA (truncated), div_by_zero=0.
REQ-030 SHALL cover 0xBF800000 / 0x00000000 (-1/0) -> result 0xFF800000, div_by_zero=1, done at T+2; 0x00000000 / 0x40A00000 -> 0x00000000, done at T+2.
REQ-031 SHALL cover 0x7F000000 / 0x3E800000 (2^127/0.25) -> 0x7F800000; 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
REQ-032 SHALL cover start pulsed during DIVIDE -> ignored, original result delivered at T+28; start again in DONE -> new result at T'+28.
REQ-033 SHALL cover reset asserted at T+10 of an operation -> done=0, busy=0, result=0 next edge; no done pulse follows.

Source files
------------

// File: rtl/fpdiv.sv
// Single-precision floating-point divider: 25-step restoring mantissa division,
// truncating normalization, no denormal/NaN/Inf decoding.
module fpdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        div_by_zero
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] NORM   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              go_q, go_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d;
    logic [23:0]       mb_q, mb_d;
    logic [24:0]       r_q, r_d;
    logic [24:0]       q_q, q_d;
    logic [4:0]        cnt_q, cnt_d;
    logic signed [9:0] e_q, e_d;
    logic [31:0]       result_q, result_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              dbz_q, dbz_d;

    logic              sign_c;
    logic [23:0]       diff_c;
    logic [22:0]       mant_c;
    logic signed [9:0] en_c;

    always_comb begin
        state_d  = state_q;
        go_d     = go_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        mb_d     = mb_q;
        r_d      = r_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        e_d      = e_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;
        dbz_d    = dbz_q;
        sign_c   = a_q[31] ^ b_q[31];
        diff_c   = r_q[23:0] - mb_q;
        mant_c   = '0;
        en_c     = '0;

        case (state_q)
            IDLE, DONE: begin
                // Operands are captured on the start edge; the FSM moves one edge later,
                // so done/result stay visible through the cycle after start.
                if (go_q) begin
                    state_d = SETUP;
                    go_d    = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end else if (start) begin
                    a_d  = dataa;
                    b_d  = datab;
                    go_d = 1'b1;
                end
            end
            SETUP: begin
                sign_d = sign_c;
                if (b_q[30:0] == 31'h0) begin
                    result_d = {sign_c, 8'hFF, 23'h0};
                    dbz_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else if (a_q[30:0] == 31'h0) begin
                    result_d = {sign_c, 31'h0};
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    mb_d    = {1'b1, b_q[22:0]};
                    r_d     = {2'b01, a_q[22:0]};
                    q_d     = '0;
                    cnt_d   = '0;
                    e_d     = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // r < 2*mb always, so the difference fits in 24 bits when taken.
                if (r_q >= {1'b0, mb_q}) begin
                    q_d = {q_q[23:0], 1'b1};
                    r_d = {diff_c, 1'b0};
                end else begin
                    q_d = {q_q[23:0], 1'b0};
                    r_d = {r_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24)
                    state_d = NORM;
            end
            NORM: begin
                if (q_q[24]) begin
                    mant_c = q_q[23:1];
                    en_c   = e_q;
                end else begin
                    mant_c = q_q[22:0];
                    en_c   = e_q - 10'sd1;
                end
                if (en_c <= 10'sd0)
                    result_d = {sign_q, 31'h0};
                else if (en_c >= 10'sd255)
                    result_d = {sign_q, 8'hFF, 23'h0};
                else
                    result_d = {sign_q, en_c[7:0], mant_c};
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            go_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            mb_q     <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            e_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            mb_q     <= mb_d;
            r_q      <= r_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            e_q      <= e_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result      = result_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;

endmodule
